// File: rtl/data_array_pkg.sv
// data_array_pkg: read FSM state type and byte-width constant shared by data_array
package data_array_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WORD_READ = 2'd1,
        LINE_READ = 2'd2
    } state_t;

endpackage

// File: rtl/data_array.sv
// data_array: set/way line storage with word and full-line access and registered two-edge reads
// Optional DATA_ARRAY_CLEAR_ON_RESET_EN: reset also zeroes every storage byte.
module data_array
    import data_array_pkg::*;
#(
    parameter int LINE_SIZE     = 64,
    parameter int NUM_SETS      = 64,
    parameter int ASSOCIATIVITY = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            read_en,
    input  logic                            write_en,
    input  logic [$clog2(NUM_SETS)-1:0]     index,
    input  logic [$clog2(ASSOCIATIVITY)-1:0] way,
    input  logic [$clog2(LINE_SIZE)-1:0]    offset,
    input  logic [DATA_WIDTH-1:0]           write_data,
    input  logic [LINE_SIZE*8-1:0]          line_write_data,
    input  logic                            line_write_en,
    output logic [DATA_WIDTH-1:0]           read_data,
    output logic [LINE_SIZE*8-1:0]          line_read_data,
    input  logic                            line_read_en
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int WW = $clog2(ASSOCIATIVITY);
    localparam int OW = $clog2(LINE_SIZE);
    localparam int AW = IW + WW;
    localparam int LW = LINE_SIZE * BYTE_W;
    localparam int NB = DATA_WIDTH / BYTE_W;

    logic [LW-1:0]         mem [NUM_SETS*ASSOCIATIVITY];
    state_t                state, state_next;
    logic [IW-1:0]         idx_q;
    logic [WW-1:0]         way_q;
    logic [OW-1:0]         off_q;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [LW-1:0]         wr_line;
    logic [DATA_WIDTH-1:0] rd_word;

    assign wr_addr = {index, way};
    assign rd_addr = {idx_q, way_q};

    // Bytes past the end of the line are dropped on write and read back as zero.
    always_comb begin
        wr_line = mem[wr_addr];
        for (int k = 0; k < NB; k++)
            if (int'(offset) + k < LINE_SIZE)
                wr_line[BYTE_W*(int'(offset)+k) +: BYTE_W] = write_data[BYTE_W*k +: BYTE_W];
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NB; k++)
            if (int'(off_q) + k < LINE_SIZE)
                rd_word[BYTE_W*k +: BYTE_W] = mem[rd_addr][BYTE_W*(int'(off_q)+k) +: BYTE_W];
    end

    always_comb begin
        state_next = (state == IDLE) ? (read_en ? WORD_READ : line_read_en ? LINE_READ : IDLE) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            read_data      <= '0;
            line_read_data <= '0;
            idx_q          <= '0;
            way_q          <= '0;
            off_q          <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && read_en) begin
                idx_q <= index;
                way_q <= way;
                off_q <= offset;
            end else if (state == IDLE && line_read_en) begin
                idx_q <= index;
                way_q <= way;
            end
            if (state == WORD_READ)
                read_data <= rd_word;
            if (state == LINE_READ)
                line_read_data <= mem[rd_addr];
        end
    end

`ifdef DATA_ARRAY_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS*ASSOCIATIVITY; i++)
                mem[i] <= '0;
        end else if (line_write_en)
            mem[wr_addr] <= line_write_data;
        else if (write_en)
            mem[wr_addr] <= wr_line;
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (line_write_en)
                mem[wr_addr] <= line_write_data;
            else if (write_en)
                mem[wr_addr] <= wr_line;
        end
    end
`endif

endmodule

// File: tb/tb_data_array.sv
// tb_data_array: directed and randomized checks of data_array against a byte-array reference model
module tb_data_array;
    import data_array_pkg::*;

    localparam int LS = 16;
    localparam int NS = 4;
    localparam int AS = 2;

    logic         clk = 1'b0;
    logic         rst, read_en, write_en, line_write_en, line_read_en;
    logic [1:0]   index;
    logic [0:0]   way;
    logic [3:0]   offset;
    logic [31:0]  write_data, read_data, saved_word;
    logic [127:0] line_write_data, line_read_data, saved_line, l;
    logic [7:0]   m [NS][AS][LS];
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    data_array #(.LINE_SIZE(LS), .NUM_SETS(NS), .ASSOCIATIVITY(AS), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .index(index), .way(way),
        .offset(offset), .write_data(write_data), .line_write_data(line_write_data),
        .line_write_en(line_write_en), .read_data(read_data), .line_read_data(line_read_data),
        .line_read_en(line_read_en)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void m_word_write(int i, int w, int o, logic [31:0] d);
        for (int k = 0; k < 4; k++)
            if (o + k < LS) m[i][w][o+k] = d[8*k +: 8];
    endfunction

    function automatic void m_line_write(int i, int w, logic [127:0] d);
        for (int b = 0; b < LS; b++) m[i][w][b] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] m_word(int i, int w, int o);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++)
            if (o + k < LS) r[8*k +: 8] = m[i][w][o+k];
        return r;
    endfunction

    function automatic logic [127:0] m_line(int i, int w);
        logic [127:0] r;
        for (int b = 0; b < LS; b++) r[8*b +: 8] = m[i][w][b];
        return r;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wr_word(input int i, input int w, input int o, input logic [31:0] d);
        index = 2'(i); way = 1'(w); offset = 4'(o); write_data = d; write_en = 1'b1;
        tick;
        write_en = 1'b0;
        m_word_write(i, w, o, d);
    endtask

    task automatic wr_line(input int i, input int w, input logic [127:0] d);
        index = 2'(i); way = 1'(w); line_write_data = d; line_write_en = 1'b1;
        tick;
        line_write_en = 1'b0;
        m_line_write(i, w, d);
    endtask

    task automatic rd_word(input string tag, input int i, input int w, input int o);
        index = 2'(i); way = 1'(w); offset = 4'(o); read_en = 1'b1;
        tick;
        read_en = 1'b0;
        index = 2'($urandom); way = 1'($urandom); offset = 4'($urandom);
        check({tag, "_state"}, 128'(dut.state), 128'(1));
        tick;
        check(tag, 128'(read_data), 128'(m_word(i, w, o)));
    endtask

    task automatic rd_line(input string tag, input int i, input int w);
        index = 2'(i); way = 1'(w); line_read_en = 1'b1;
        tick;
        line_read_en = 1'b0;
        index = 2'($urandom); way = 1'($urandom);
        check({tag, "_state"}, 128'(dut.state), 128'(2));
        tick;
        check(tag, line_read_data, m_line(i, w));
    endtask

    initial begin
        rst = 1'b1; read_en = 1'b0; write_en = 1'b0; line_write_en = 1'b0; line_read_en = 1'b0;
        index = '0; way = '0; offset = '0; write_data = '0; line_write_data = '0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_state", 128'(dut.state), 128'(0));
        check("rst_read_data", 128'(read_data), 128'(0));
        check("rst_line_read_data", line_read_data, 128'(0));

        for (int i = 0; i < NS; i++)
            for (int w = 0; w < AS; w++) wr_line(i, w, rand_line());

        wr_word(2, 1, 8, 32'hABCD1234);
        rd_word("word_rw", 2, 1, 8);
        check("word_rw_const", 128'(read_data), 128'(32'hABCD1234));

        for (int b = 0; b < LS; b++) l[8*b +: 8] = 8'(b + 1);
        wr_line(1, 0, l);
        rd_line("line_rw", 1, 0);
        check("line_rw_const", line_read_data, 128'h100f0e0d0c0b0a090807060504030201);

        wr_word(1, 1, 4, 32'h5555AAAA);
        rd_word("way_iso", 1, 0, 4);
        check("way_iso_const", 128'(read_data), 128'(32'h08070605));

        wr_word(1, 0, 14, 32'h11223344);
        rd_word("boundary", 1, 0, 14);
        check("boundary_const", 128'(read_data), 128'(32'h00003344));
        rd_line("boundary_line", 1, 0);
        check("boundary_line_const", line_read_data, 128'h3344_0e0d0c0b0a0908070605040302_01);

        saved_line = line_read_data;
        index = 2'd2; way = 1'd1; offset = 4'd8; read_en = 1'b1; line_read_en = 1'b1;
        tick;
        line_read_en = 1'b0;
        check("prio_state", 128'(dut.state), 128'(1));
        index = 2'd1; way = 1'd0; offset = 4'd14;
        tick;
        check("prio_word", 128'(read_data), 128'(32'hABCD1234));
        check("prio_state_idle", 128'(dut.state), 128'(0));
        check("prio_line_held", line_read_data, saved_line);
        read_en = 1'b0;
        tick;
        check("ignored_read_state", 128'(dut.state), 128'(0));
        check("ignored_read_hold", 128'(read_data), 128'(32'hABCD1234));

        l = rand_line();
        index = 2'd3; way = 1'd0; offset = 4'd0; write_data = 32'hDEADBEEF;
        line_write_data = l; write_en = 1'b1; line_write_en = 1'b1;
        tick;
        write_en = 1'b0; line_write_en = 1'b0;
        m_line_write(3, 0, l);
        rd_line("line_wins", 3, 0);

        index = 2'd0; way = 1'd1; offset = 4'd2; write_data = 32'h13579BDF;
        write_en = 1'b1; read_en = 1'b1;
        tick;
        write_en = 1'b0; read_en = 1'b0;
        m_word_write(0, 1, 2, 32'h13579BDF);
        tick;
        check("write_visible", 128'(read_data), 128'(m_word(0, 1, 2)));

        for (int n = 0; n < 60; n++) begin
            automatic int i = $urandom_range(0, NS-1);
            automatic int w = $urandom_range(0, AS-1);
            automatic int o = $urandom_range(0, LS-1);
            case ($urandom_range(0, 3))
                0: wr_word(i, w, o, $urandom);
                1: wr_line(i, w, rand_line());
                2: begin
                    saved_line = line_read_data;
                    rd_word("rand_word", i, w, o);
                    check("rand_line_held", line_read_data, saved_line);
                end
                default: begin
                    saved_word = read_data;
                    rd_line("rand_line", i, w);
                    check("rand_word_held", 128'(read_data), 128'(saved_word));
                end
            endcase
        end

        wr_word(0, 0, 0, 32'hCAFEF00D);
        rd_word("pre_reset", 0, 0, 0);
        rd_line("pre_reset_line", 2, 1);
        index = 2'd0; way = 1'd0; offset = 4'd0; read_en = 1'b1;
        tick;
        read_en = 1'b0;
        rst = 1'b1;
        index = 2'd3; way = 1'd1; offset = 4'd0; write_data = 32'h0BADF00D; write_en = 1'b1;
        tick;
        rst = 1'b0; write_en = 1'b0;
`ifdef DATA_ARRAY_CLEAR_ON_RESET_EN
        for (int i = 0; i < NS; i++)
            for (int w = 0; w < AS; w++) m_line_write(i, w, '0);
`endif
        check("midread_state", 128'(dut.state), 128'(0));
        check("midread_read_data", 128'(read_data), 128'(0));
        check("midread_line_data", line_read_data, 128'(0));
        tick;
        check("midread_abandoned", 128'(read_data), 128'(0));
        rd_word("post_reset", 0, 0, 0);
        rd_line("post_reset_line", 3, 1);
        rd_line("post_reset_line2", 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
